rgb_frame_sequencer: RTL and testbench

- Controller that sequences the bit-serial RGB converter across one image frame.
- Gates the converter's shift-enable from the Raspberry Pi bit stream and counts completed pixels into column/row position.
- Buffers tagged pixels in a small FIFO and presents them downstream on a valid/ready interface with start-of-frame, end-of-line and end-of-frame markers.

---
 rtl/rgb_frame_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_rgb_frame_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_frame_sequencer.sv
// rgb_frame_sequencer: frame-level controller for the bit-serial RGB converter.
// Gates the converter shift enable, tracks column/row of completed pixels,
// and buffers tagged pixels in a small FIFO toward a valid/ready consumer.
// Optional build macro RGB_FRAME_CHECKSUM_EN adds a 24-bit running sum of
// accepted pixels on frame_checksum.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for frame_start, converter shift enable held low
// RECEIVE | passing bit_valid through, pushing completed pixels
// DRAIN   | last pixel seen, waiting for the FIFO to empty
// DONE    | one-cycle frame_done pulse, then back to IDLE
module rgb_frame_sequencer #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        frame_abort,
  input  logic        bit_valid,
  output logic        conv_input_valid,
  input  logic        conv_output_valid,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic [23:0] pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        busy,
  output logic        frame_done,
`ifdef RGB_FRAME_CHECKSUM_EN
  output logic [23:0] frame_checksum,
`endif
  output logic        overflow
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RECEIVE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [26:0]   mem [FIFO_DEPTH];
  logic [26:0]   head;
  logic          overflow_q;

  logic empty, full, push_req, push_ok, pop, drop, start_ok;
  logic tag_sof, tag_eol, tag_eof;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = !empty && pix_ready;
  assign push_req = (state_q == S_RECEIVE) && conv_output_valid && !frame_abort;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign start_ok = (state_q == S_IDLE) && frame_start && !frame_abort;

  assign tag_sof = (col_q == '0) && (row_q == '0);
  assign tag_eol = (col_q == COL_LAST);
  assign tag_eof = tag_eol && (row_q == ROW_LAST);

  assign head = mem[rd_ptr[AW-1:0]];

  // Next-state and status outputs; abort overrides every transition.
  always_comb begin
    state_d          = state_q;
    conv_input_valid = 1'b0;
    busy             = (state_q != S_IDLE);
    frame_done       = 1'b0;
    case (state_q)
      S_IDLE:    if (frame_start) state_d = S_RECEIVE;
      S_RECEIVE: begin
        conv_input_valid = bit_valid;
        if (push_req && tag_eof) state_d = S_DRAIN;
      end
      S_DRAIN:   if (empty) state_d = S_DONE;
      S_DONE:    begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
    if (frame_abort) state_d = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Column/row position of the next completed pixel; dropped pixels still count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (frame_abort || start_ok) begin
      col_q <= '0;
      row_q <= '0;
    end else if (push_req) begin
      if (tag_eol) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // FIFO pointers; abort flushes by collapsing both pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (frame_abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {red, green, blue, tag_sof, tag_eol, tag_eof};
  end

  // Sticky drop flag, cleared only by an accepted frame_start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      overflow_q <= 1'b0;
    else if (start_ok) overflow_q <= 1'b0;
    else if (drop)     overflow_q <= 1'b1;
  end

  // Head entry is masked to zero while empty so stale storage never leaks out.
  always_comb begin
    pix_valid = !empty;
    pix_data  = 24'd0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
    pix_eof   = 1'b0;
    if (!empty) begin
      pix_data = head[26:3];
      pix_sof  = head[2];
      pix_eol  = head[1];
      pix_eof  = head[0];
    end
  end

  assign overflow = overflow_q;

`ifdef RGB_FRAME_CHECKSUM_EN
  logic [23:0] checksum_q;

  // Running sum of accepted pixels; only pushes move it, so it freezes after RECEIVE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      checksum_q <= 24'd0;
    else if (start_ok) checksum_q <= 24'd0;
    else if (push_ok)  checksum_q <= checksum_q + {red, green, blue};
  end

  assign frame_checksum = checksum_q;
`endif

endmodule

// File: tb/tb_rgb_frame_sequencer.sv
// Scoreboard bench for rgb_frame_sequencer with a small 4x2 frame and 4-deep FIFO.
module tb_rgb_frame_sequencer;

  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        frame_abort = 1'b0;
  logic        bit_valid = 1'b0;
  logic        conv_input_valid;
  logic        conv_output_valid = 1'b0;
  logic [7:0]  red = '0, green = '0, blue = '0;
  logic [23:0] pix_data;
  logic        pix_sof, pix_eol, pix_eof, pix_valid;
  logic        pix_ready = 1'b0;
  logic        busy, frame_done, overflow;
`ifdef RGB_FRAME_CHECKSUM_EN
  logic [23:0] frame_checksum;
`endif

  rgb_frame_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .frame_abort(frame_abort),
    .bit_valid(bit_valid), .conv_input_valid(conv_input_valid),
    .conv_output_valid(conv_output_valid), .red(red), .green(green), .blue(blue),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy), .frame_done(frame_done),
`ifdef RGB_FRAME_CHECKSUM_EN
    .frame_checksum(frame_checksum),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: phase 0 idle, 1 receiving, 2 draining, 3 done pulse.
  int          phase = 0;
  int          k = 0;
  int          occ = 0;
  bit          m_ovf = 0;
  logic [23:0] m_sum = '0;
  logic [26:0] exp_q[$];

  always @(posedge clk or negedge reset_n) begin
    bit          do_pop;
    logic [23:0] px;
    if (!reset_n) begin
      phase = 0; k = 0; occ = 0; m_ovf = 0; m_sum = '0;
      exp_q.delete();
    end else begin
      do_pop = (occ > 0) && pix_ready;
      if (frame_abort) begin
        phase = 0; k = 0; occ = 0;
        exp_q.delete();
      end else begin
        case (phase)
          0: if (frame_start) begin
               phase = 1; k = 0; m_ovf = 0; m_sum = '0;
             end
          1: if (conv_output_valid) begin
               px = {red, green, blue};
               if (occ < D || do_pop) begin
                 exp_q.push_back({px, k == 0, (k % W) == W - 1, k == W * H - 1});
                 occ++;
                 m_sum = m_sum + px;
               end else begin
                 m_ovf = 1;
               end
               if (k == W * H - 1) phase = 2;
               k = (k + 1) % (W * H);
             end
          2: if (occ == 0) phase = 3;
          default: phase = 0;
        endcase
        if (do_pop) occ--;
      end
    end
  end

  // Monitor: compares status every cycle and the head pixel whenever one is expected.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("pix_valid", pix_valid, occ > 0);
      chk("busy", busy, phase != 0);
      chk("frame_done", frame_done, phase == 3);
      chk("overflow", overflow, m_ovf);
      chk("conv_input_valid", conv_input_valid, (phase == 1) && bit_valid);
`ifdef RGB_FRAME_CHECKSUM_EN
      chk("frame_checksum", frame_checksum, m_sum);
`endif
      if (occ > 0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
        end else begin
          chk("pixel", {pix_data, pix_sof, pix_eol, pix_eof}, exp_q[0]);
          if (pix_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic push_px(input logic [23:0] px, input logic rdy);
    conv_output_valid = 1'b1;
    {red, green, blue} = px;
    pix_ready = rdy;
    bit_valid = $urandom_range(0, 1);
    tick();
    conv_output_valid = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    pix_ready = 1'b1;
    while (phase != 0 && n < budget) begin
      tick();
      n++;
    end
    if (phase != 0) begin
      n_checks++;
      $display("FAIL wait_idle: got timeout expected return to idle at %0t", $time);
    end
    tick();
  endtask

  task automatic random_frame(input int ready_pct);
    int n = 0;
    start_frame();
    while (phase != 0 && n < 400) begin
      bit_valid = $urandom_range(0, 1);
      conv_output_valid = ($urandom_range(0, 2) == 0);
      {red, green, blue} = 24'($urandom);
      pix_ready = ($urandom_range(0, 99) < ready_pct);
      frame_start = ($urandom_range(0, 9) == 0);
      tick();
      n++;
    end
    conv_output_valid = 1'b0;
    frame_start = 1'b0;
    bit_valid = 1'b0;
    if (phase != 0) begin
      n_checks++;
      $display("FAIL random_frame: got timeout expected frame completion at %0t", $time);
    end
    tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("reset_pix_valid", pix_valid, 0);
    chk("reset_pix_data", pix_data, 0);
    chk("reset_busy", busy, 0);
    reset_n = 1'b1;
    tick();

    // Frame 1: eight pixels 1..8, consumer always ready.
    start_frame();
    for (int p = 1; p <= 8; p++) begin
      push_px(24'(p), 1'b1);
      tick();
    end
    wait_idle(50);
    chk("f1_overflow", overflow, 0);
`ifdef RGB_FRAME_CHECKSUM_EN
    chk("f1_checksum", frame_checksum, 24'h000024);
`endif

    // Frame 2: consumer stalled, pixels 5..8 dropped; start pulses in RECEIVE and DRAIN.
    start_frame();
    for (int p = 1; p <= 8; p++) begin
      frame_start = (p == 3);
      push_px(24'(p), 1'b0);
    end
    frame_start = 1'b1;
    pix_ready = 1'b0;
    tick();
    frame_start = 1'b0;
    chk("f2_overflow", overflow, 1);
    chk("f2_busy_drain", busy, 1);
    wait_idle(50);

    // Frame 3: fill to full, then push with a simultaneous pop.
    start_frame();
    for (int p = 1; p <= 4; p++) push_px(24'h100 + 24'(p), 1'b0);
    push_px(24'h105, 1'b1);
    chk("f3_no_overflow", overflow, 0);
    for (int p = 6; p <= 8; p++) push_px(24'h100 + 24'(p), 1'b1);
    wait_idle(50);
    chk("f3_overflow_after", overflow, 0);

    // Frame 4: abort after three pixels, then a clean frame.
    start_frame();
    for (int p = 1; p <= 3; p++) push_px(24'h200 + 24'(p), 1'b0);
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_pix_valid", pix_valid, 0);
    start_frame();
    for (int p = 1; p <= 8; p++) push_px(24'h300 + 24'(p), 1'b1);
    wait_idle(50);

    // Randomised frames with varying back-pressure.
    for (int f = 0; f < 8; f++) random_frame((f % 4) * 30 + 10);

    // Asynchronous reset in the middle of RECEIVE.
    start_frame();
    push_px(24'habcdef, 1'b0);
    push_px(24'h123456, 1'b0);
    bit_valid = 1'b1;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("areset_conv_input_valid", conv_input_valid, 0);
    chk("areset_pix_valid", pix_valid, 0);
    chk("areset_pix_data", pix_data, 0);
    chk("areset_busy", busy, 0);
    chk("areset_tags", {pix_sof, pix_eol, pix_eof}, 0);
    chk("areset_overflow", overflow, 0);
    tick();
    bit_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    random_frame(70);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
